// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter.
// Holds FSM state codes, access-size codes and core width defaults.
package mem_port_arbiter_pkg;

  localparam int CORE_XLEN = 32;
  localparam int CORE_MAX_BIT_POS = CORE_XLEN - 1;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'b00,
    ARB_GRANT_IF = 2'b01,
    ARB_GRANT_LS = 2'b10,
    ARB_RESP     = 2'b11
  } arb_state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  // Counter width able to hold limit-1 without wrapping.
  function automatic int cnt_width(input int limit);
    if (limit < 2) begin
      return 1;
    end
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Grant-cycle counter for the memory port arbiter.
// Flags expiry on the cycle that would make limit grant cycles.
module arb_timeout_counter #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] count;
  logic          armed;

  // A zero limit means the timeout is switched off.
  assign armed = (limit != '0);

  assign expired = enable && armed &&
                   (count >= limit - CW'(1));

  // Count grant cycles, parking once the limit is reached.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (enable && armed && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the data-memory bus between fetch and load/store.
// Define ARB_RR_EN for round-robin on contention; default is LS-first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN           = CORE_XLEN,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_read_en,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  input  logic            ls_read_en,
  input  logic            ls_write_en,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [1:0]      ls_byte_size,
  output logic [XLEN-1:0] ls_rdata,
  output logic            ls_read_ready,
  output logic            ls_write_ready,
  output logic            bus_read_en,
  output logic            bus_write_en,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [1:0]      bus_byte_size,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ready,
  output logic            busy,
  output logic            timeout_err
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  arb_state_t      state;
  logic            if_req;
  logic            ls_req;
  logic            ls_first;
  logic            pick_ls;
  logic            in_grant;
  logic            expired;
  logic            finish;
  logic [XLEN-1:0] win_rdata;

  assign if_req   = if_read_en;
  assign ls_req   = ls_read_en | ls_write_en;
  assign in_grant = (state == ARB_GRANT_IF) ||
                    (state == ARB_GRANT_LS);
  assign busy     = (state != ARB_IDLE);

  // Completion either by the memory or by the watchdog.
  assign finish    = bus_ready | expired;
  assign win_rdata = bus_ready ? bus_rdata : '0;

`ifdef ARB_RR_EN
  logic last_ls;

  // Remember the last winner so a contended pair alternates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_ls <= 1'b0;
    end else if (state == ARB_IDLE && (if_req || ls_req)) begin
      last_ls <= pick_ls;
    end
  end

  assign ls_first = !last_ls;
`else
  assign ls_first = 1'b1;
`endif

  // Choose the winner of a pending request in IDLE.
  always_comb begin
    pick_ls = 1'b0;
    unique case (1'b1)
      (ls_req && if_req):  pick_ls = ls_first;
      (ls_req && !if_req): pick_ls = 1'b1;
      default:             pick_ls = 1'b0;
    endcase
  end

  arb_timeout_counter #(
    .CW (CW)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (in_grant),
    .clear   (!in_grant),
    .limit   (LIMIT),
    .expired (expired)
  );

  // Arbitration FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ARB_IDLE;
      if_rdata       <= '0;
      if_ready       <= 1'b0;
      ls_rdata       <= '0;
      ls_read_ready  <= 1'b0;
      ls_write_ready <= 1'b0;
      bus_read_en    <= 1'b0;
      bus_write_en   <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_byte_size  <= SZ_WORD;
      timeout_err    <= 1'b0;
    end else begin
      if_ready       <= 1'b0;
      ls_read_ready  <= 1'b0;
      ls_write_ready <= 1'b0;
      timeout_err    <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (pick_ls) begin
            state         <= ARB_GRANT_LS;
            bus_write_en  <= ls_write_en;
            bus_read_en   <= !ls_write_en;
            bus_addr      <= ls_addr;
            bus_wdata     <= ls_wdata;
            bus_byte_size <= ls_byte_size;
          end else if (if_req) begin
            state         <= ARB_GRANT_IF;
            bus_write_en  <= 1'b0;
            bus_read_en   <= 1'b1;
            bus_addr      <= if_addr;
            bus_wdata     <= '0;
            bus_byte_size <= SZ_WORD;
          end
        end
        ARB_GRANT_IF: begin
          if (finish) begin
            state        <= ARB_RESP;
            bus_read_en  <= 1'b0;
            bus_write_en <= 1'b0;
            if_rdata     <= win_rdata;
            if_ready     <= 1'b1;
            timeout_err  <= !bus_ready;
          end
        end
        ARB_GRANT_LS: begin
          if (finish) begin
            state          <= ARB_RESP;
            bus_read_en    <= 1'b0;
            bus_write_en   <= 1'b0;
            ls_read_ready  <= bus_read_en;
            ls_write_ready <= bus_write_en;
            timeout_err    <= !bus_ready;
            if (bus_read_en) begin
              ls_rdata <= win_rdata;
            end
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (timeout set to 4).
// Reference model tracks last winner, data registers and timing.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_read_en;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        ls_read_en;
  logic        ls_write_en;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [1:0]  ls_byte_size;
  logic [31:0] ls_rdata;
  logic        ls_read_ready;
  logic        ls_write_ready;
  logic        bus_read_en;
  logic        bus_write_en;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [1:0]  bus_byte_size;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  // reference model state
  bit          m_last_ls;
  logic [31:0] m_ls_rdata;

  // observations from serve()
  logic [31:0] o_addr, o_wdata, o_if_d, o_ls_d;
  logic [1:0]  o_size;
  logic        o_rd, o_wr, o_held, o_hung;
  logic        o_strobe1, o_strobe2, o_busy1, o_busy2;
  logic        o_extra;
  int          o_at, n_if, n_lr, n_lw, n_to;

  mem_port_arbiter #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_read_en     (if_read_en),
    .if_addr        (if_addr),
    .if_rdata       (if_rdata),
    .if_ready       (if_ready),
    .ls_read_en     (ls_read_en),
    .ls_write_en    (ls_write_en),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_byte_size   (ls_byte_size),
    .ls_rdata       (ls_rdata),
    .ls_read_ready  (ls_read_ready),
    .ls_write_ready (ls_write_ready),
    .bus_read_en    (bus_read_en),
    .bus_write_en   (bus_write_en),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_byte_size  (bus_byte_size),
    .bus_rdata      (bus_rdata),
    .bus_ready      (bus_ready),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner rule on contention, from the arbitration policy.
  function automatic bit exp_pick_ls(input bit ifr, input bit lsr);
`ifdef ARB_RR_EN
    if (ifr && lsr) return !m_last_ls;
`else
    if (ifr && lsr) return 1'b1;
`endif
    return lsr;
  endfunction

  // Requests must be driven and DUT idle. Grants, answers after
  // lat grant cycles (never if lat>TO), records what happens.
  task automatic serve(input int lat, input logic [31:0] rd);
    step();
    o_addr = bus_addr; o_wdata = bus_wdata; o_size = bus_byte_size;
    o_rd = bus_read_en; o_wr = bus_write_en;
    o_held = 1'b1; o_hung = 1'b1; o_at = 0;
    n_if = 0; n_lr = 0; n_lw = 0; n_to = 0;
    for (int k = 1; k <= 20; k++) begin
      bus_ready = (k == lat);
      bus_rdata = (k == lat) ? rd : $urandom;
      step();
      bus_ready = 1'b0;
      if (if_ready || ls_read_ready || ls_write_ready || timeout_err) begin
        o_hung = 1'b0; o_at = k;
        n_if = int'(if_ready); n_lr = int'(ls_read_ready);
        n_lw = int'(ls_write_ready); n_to = int'(timeout_err);
        o_if_d = if_rdata; o_ls_d = ls_rdata;
        o_strobe1 = bus_read_en | bus_write_en; o_busy1 = busy;
        if (if_ready) if_read_en = 1'b0;
        if (ls_read_ready || ls_write_ready) begin
          ls_read_en = 1'b0; ls_write_en = 1'b0;
        end
        step();
        o_extra = if_ready | ls_read_ready | ls_write_ready | timeout_err;
        o_strobe2 = bus_read_en | bus_write_en; o_busy2 = busy;
        break;
      end
      if (bus_addr !== o_addr || bus_read_en !== o_rd ||
          bus_write_en !== o_wr || bus_byte_size !== o_size ||
          bus_wdata !== o_wdata)
        o_held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    total++;
    if ({if_rdata, if_ready, ls_rdata, ls_read_ready, ls_write_ready,
         bus_read_en, bus_write_en, bus_addr, bus_wdata, bus_byte_size,
         busy, timeout_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    rst = 1'b1;
    m_last_ls = 1'b0; m_ls_rdata = '0;
  endtask

  task automatic test_reset_mid_grant();
    ls_write_en = 1'b1; ls_addr = 32'h80; ls_wdata = 32'h1234;
    ls_byte_size = 2'd0;
    step();
    total++;
    if (bus_write_en !== 1'b1) begin
      bad++; $display("FAIL rmg_grant: bus_write_en=%b want 1", bus_write_en);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if ({ls_write_ready, bus_read_en, bus_write_en, bus_addr, bus_wdata,
         bus_byte_size, busy, ls_rdata, if_rdata} !== '0) begin
      bad++; $display("FAIL rmg_cleared: outputs nonzero after reset");
    end
    rst = 1'b1; ls_write_en = 1'b0;
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    total++;
    if ({ls_write_ready, bus_write_en, busy} !== 3'b000) begin
      bad++;
      $display("FAIL rmg_late_ready: wr_rdy/strobe/busy=%b want 000",
               {ls_write_ready, bus_write_en, busy});
    end
    step();
    total++;
    if (ls_write_ready !== 1'b0) begin
      bad++; $display("FAIL rmg_no_pulse: ls_write_ready=1 want 0");
    end
    m_last_ls = 1'b0; m_ls_rdata = '0;
  endtask

  task automatic test_lone_fetch();
    if_read_en = 1'b1; if_addr = 32'h100;
    serve(2, 32'hDEADBEEF);
    m_last_ls = 1'b0;
    total++;
    if (o_hung) begin bad++; $display("FAIL lf_hung: no ready pulse"); end
    total++;
    if ({o_rd, o_wr, o_size} !== 4'b1000 || o_addr !== 32'h100) begin
      bad++;
      $display("FAIL lf_bus: rd/wr/sz=%b addr=%h want 1000 100",
               {o_rd, o_wr, o_size}, o_addr);
    end
    total++;
    if (o_at !== 2 || n_if !== 1 || n_lr + n_lw + n_to !== 0) begin
      bad++;
      $display("FAIL lf_pulse: at=%0d if=%0d lr=%0d lw=%0d to=%0d want 2 1 0 0 0",
               o_at, n_if, n_lr, n_lw, n_to);
    end
    total++;
    if (o_if_d !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lf_data: got %h want deadbeef", o_if_d);
    end
    total++;
    if (!o_held || o_strobe1 || !o_busy1 || o_busy2 || o_extra) begin
      bad++;
      $display("FAIL lf_ctrl: held=%b strobe=%b busy=%b%b extra=%b want 1 0 10 0",
               o_held, o_strobe1, o_busy1, o_busy2, o_extra);
    end
  endtask

  task automatic test_priority();
    bit pls;
    pls = exp_pick_ls(1'b1, 1'b1);
    if_read_en = 1'b1; if_addr = 32'h300;
    ls_read_en = 1'b1; ls_addr = 32'h2003; ls_byte_size = 2'd1;
    ls_wdata = 32'h0;
    serve(1, 32'h11223344);
    m_last_ls = pls;
    total++;
    if (o_addr !== (pls ? 32'h2003 : 32'h300) ||
        o_size !== (pls ? 2'd1 : 2'd0)) begin
      bad++;
      $display("FAIL pr_first: addr=%h size=%0d want ls=%b", o_addr, o_size, pls);
    end
    total++;
    if (o_strobe2 !== 1'b0 || o_busy2 !== 1'b0) begin
      bad++; $display("FAIL pr_resp_gap: strobe=%b busy=%b want 0 0",
                      o_strobe2, o_busy2);
    end
    if (pls) m_ls_rdata = 32'h11223344;
    serve(3, 32'h55667788);
    total++;
    if (o_addr !== (pls ? 32'h300 : 32'h2003) || o_at !== 3) begin
      bad++;
      $display("FAIL pr_second: addr=%h at=%0d want other requester at 3",
               o_addr, o_at);
    end
    total++;
    if ((pls ? o_if_d : o_ls_d) !== 32'h55667788) begin
      bad++; $display("FAIL pr_data: got %h want 55667788",
                      pls ? o_if_d : o_ls_d);
    end
    m_last_ls = !pls;
    if (!pls) m_ls_rdata = 32'h55667788;
  endtask

  task automatic test_store_conflict();
    ls_read_en = 1'b1; ls_write_en = 1'b1;
    ls_addr = 32'h40; ls_wdata = 32'h5A; ls_byte_size = 2'd0;
    serve(2, 32'hCAFEF00D);
    m_last_ls = 1'b1;
    total++;
    if ({o_wr, o_rd} !== 2'b10 || o_wdata !== 32'h5A) begin
      bad++;
      $display("FAIL st_bus: wr/rd=%b wdata=%h want 10 5a", {o_wr, o_rd}, o_wdata);
    end
    total++;
    if (n_lw !== 1 || n_lr !== 0 || n_if !== 0) begin
      bad++; $display("FAIL st_pulse: lw=%0d lr=%0d if=%0d want 1 0 0",
                      n_lw, n_lr, n_if);
    end
    total++;
    if (o_ls_d !== m_ls_rdata) begin
      bad++; $display("FAIL st_rdata: got %h want %h", o_ls_d, m_ls_rdata);
    end
  endtask

  task automatic test_timeout();
    ls_read_en = 1'b1; ls_addr = 32'h900; ls_byte_size = 2'd2;
    serve(99, 32'hFFFFFFFF);
    m_last_ls = 1'b1; m_ls_rdata = '0;
    total++;
    if (o_hung || o_at !== TO || n_to !== 1 || n_lr !== 1) begin
      bad++;
      $display("FAIL to_pulse: at=%0d to=%0d lr=%0d want %0d 1 1",
               o_at, n_to, n_lr, TO);
    end
    total++;
    if (o_ls_d !== 32'h0 || o_strobe1 !== 1'b0) begin
      bad++; $display("FAIL to_abort: rdata=%h strobe=%b want 0 0",
                      o_ls_d, o_strobe1);
    end
  endtask

  task automatic test_back_to_back();
    bit pls;
    logic [31:0] rd;
    if_addr = 32'h400; ls_addr = 32'h404; ls_byte_size = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if_read_en = 1'b1; ls_read_en = 1'b1; ls_write_en = 1'b0;
      pls = exp_pick_ls(1'b1, 1'b1);
      rd = $urandom;
      serve(1 + i, rd);
      m_last_ls = pls;
      if (pls) m_ls_rdata = rd;
      total++;
      if (o_addr !== (pls ? 32'h404 : 32'h400)) begin
        bad++; $display("FAIL b2b_grant%0d: addr=%h want ls=%b", i, o_addr, pls);
      end
    end
    if_read_en = 1'b0; ls_read_en = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit pls, wr, ok;
    int lat, exp_at;
    logic [31:0] rd, exp_d;
    for (int i = 0; i < 40; i++) begin
      if (!if_read_en && ($urandom_range(0, 1) == 1)) begin
        if_read_en = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_read_en && !ls_write_en && ($urandom_range(0, 1) == 1)) begin
        ls_read_en = 1'($urandom_range(0, 1));
        ls_write_en = !ls_read_en || ($urandom_range(0, 3) == 0);
        ls_addr = $urandom; ls_wdata = $urandom;
        ls_byte_size = 2'($urandom_range(0, 2));
      end
      if (!if_read_en && !ls_read_en && !ls_write_en) begin
        if_read_en = 1'b1; if_addr = $urandom;
      end
      pls = exp_pick_ls(if_read_en, ls_read_en | ls_write_en);
      wr = pls && ls_write_en;
      lat = wr ? $urandom_range(1, TO) : $urandom_range(1, TO + 2);
      ok = (lat <= TO);
      exp_at = ok ? lat : TO;
      rd = $urandom;
      exp_d = ok ? rd : 32'h0;
      total++;
      if (pls) begin
        if (o_busy2 !== 1'b0) ;
      end
      serve(lat, rd);
      if (o_hung || o_at !== exp_at || n_to !== int'(!ok) ||
          n_if !== int'(!pls) || n_lr !== int'(pls && !wr) ||
          n_lw !== int'(wr)) begin
        bad++;
        $display("FAIL rnd%0d_pulse: at=%0d if=%0d lr=%0d lw=%0d to=%0d want at=%0d ls=%b wr=%b ok=%b",
                 i, o_at, n_if, n_lr, n_lw, n_to, exp_at, pls, wr, ok);
      end
      total++;
      if (o_rd !== !wr || o_wr !== wr || !o_held ||
          o_addr !== (pls ? ls_addr : if_addr) ||
          o_size !== (pls ? ls_byte_size : 2'd0)) begin
        bad++;
        $display("FAIL rnd%0d_bus: rd=%b wr=%b held=%b addr=%h size=%0d",
                 i, o_rd, o_wr, o_held, o_addr, o_size);
      end
      if (wr) exp_d = m_ls_rdata;
      total++;
      if ((pls ? o_ls_d : o_if_d) !== exp_d) begin
        bad++; $display("FAIL rnd%0d_data: got %h want %h",
                        i, pls ? o_ls_d : o_if_d, exp_d);
      end
      m_last_ls = pls;
      if (pls) m_ls_rdata = exp_d;
    end
  endtask

  initial begin
    if_read_en = 1'b0; if_addr = '0;
    ls_read_en = 1'b0; ls_write_en = 1'b0;
    ls_addr = '0; ls_wdata = '0; ls_byte_size = '0;
    bus_rdata = '0; bus_ready = 1'b0;
    rst = 1'b0;
    #1;
    test_reset();
    test_reset_mid_grant();
    test_lone_fetch();
    test_priority();
    test_store_conflict();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
